memory_port_arbiter: RTL

Shares the single main-memory port between the instruction-cache and data-cache controllers. Each side raises a miss or write-through request. The block grants one requester at a time with round-robin fairness, drives the memory handshake, and returns read data plus a one-cycle acknowledge. A watchdog aborts transactions whose memory never answers. It sits between the two cache controllers and main memory.

---
 rtl/mem_arb_pkg.sv | 22 ++
 rtl/rr_pick2.sv | 30 +++
 rtl/memory_port_arbiter.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared types and constants for the memory port arbiter
//
// Purpose: FSM state encoding, default bus widths and grant encodings shared
//          by memory_port_arbiter and rr_pick2.
// Ports:   none (package).
package mem_arb_pkg;

  localparam int ARB_ADDR_W = 8;   // 5-bit index + 3-bit tag
  localparam int ARB_DATA_W = 32;

  // Grant encodings, also used for the lastGrant register.
  localparam logic GRANT_I = 1'b0;
  localparam logic GRANT_D = 1'b1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SERVE_I = 2'd1,
    SERVE_D = 2'd2,
    DONE    = 2'd3
  } arb_state_t;

endpackage

// File: rtl/rr_pick2.sv
// rtl/rr_pick2.sv - combinational two-input round-robin picker
//
// Purpose: choose between the I-side and D-side requests; on a tie the side
//          that did not win last time is chosen.
// Ports:
//   ireq, dreq  in   request pair
//   last_grant  in   side granted most recently (GRANT_I / GRANT_D)
//   valid       out  at least one request is present
//   grant       out  chosen side (meaningful only when valid)
module rr_pick2
  import mem_arb_pkg::*;
(
  input  logic ireq,
  input  logic dreq,
  input  logic last_grant,
  output logic valid,
  output logic grant
);

  always_comb begin
    valid = ireq | dreq;
    grant = GRANT_I;
    if (ireq && dreq) begin
      grant = (last_grant == GRANT_I) ? GRANT_D : GRANT_I;
    end else if (dreq) begin
      grant = GRANT_D;
    end
  end

endmodule

// File: rtl/memory_port_arbiter.sv
// rtl/memory_port_arbiter.sv - shares one main-memory port between I- and D-cache
//
// Purpose: grants one cache controller at a time (round-robin on ties), runs
//          the memory read/write handshake, returns read data with a one-cycle
//          acknowledge, and aborts with err when memory never answers.
// Ports:
//   clk, reset          clock, asynchronous active-low reset
//   iReq/iAddr          I-cache read request (held until iAck)
//   iAck/iRData         I-cache completion pulse and read data
//   dReq/dWrite/dAddr/dWData  D-cache request (held until dAck)
//   dAck/dRData         D-cache completion pulse and read data
//   MsRead/MsWrite      memory command strobes (never both high)
//   MsAddr/MsWData      memory address and write data
//   MsRData/MsReady     memory read data and completion
//   err                 high together with Ack when the transaction timed out
module memory_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W  = ARB_ADDR_W,
  parameter int DATA_W  = ARB_DATA_W,
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              iReq,
  input  logic [ADDR_W-1:0] iAddr,
  output logic              iAck,
  output logic [DATA_W-1:0] iRData,
  input  logic              dReq,
  input  logic              dWrite,
  input  logic [ADDR_W-1:0] dAddr,
  input  logic [DATA_W-1:0] dWData,
  output logic              dAck,
  output logic [DATA_W-1:0] dRData,
  output logic              MsRead,
  output logic              MsWrite,
  output logic [ADDR_W-1:0] MsAddr,
  output logic [DATA_W-1:0] MsWData,
  input  logic [DATA_W-1:0] MsRData,
  input  logic              MsReady,
  output logic              err
);

  localparam int WD_W = $clog2(TIMEOUT);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

  arb_state_t        state_q, state_d;
  logic              last_q, last_d;
  logic [WD_W-1:0]   wd_q, wd_d;
  logic [ADDR_W-1:0] addr_d;
  logic [DATA_W-1:0] wdata_d;
  logic              rd_d, wr_d;
  logic              iack_d, dack_d, err_d;
  logic [DATA_W-1:0] irdata_d, drdata_d;

  logic pick_valid, pick_grant;

  rr_pick2 u_pick (
    .ireq       (iReq),
    .dreq       (dReq),
    .last_grant (last_q),
    .valid      (pick_valid),
    .grant      (pick_grant)
  );

  // Next-state and next-output logic. The memory-side outputs are themselves
  // the latched command registers, so they stay stable through SERVE.
  always_comb begin
    state_d  = state_q;
    last_d   = last_q;
    wd_d     = wd_q;
    addr_d   = MsAddr;
    wdata_d  = MsWData;
    rd_d     = MsRead;
    wr_d     = MsWrite;
    iack_d   = 1'b0;
    dack_d   = 1'b0;
    err_d    = err;
    irdata_d = iRData;
    drdata_d = dRData;

    case (state_q)
      IDLE: begin
        if (pick_valid) begin
          last_d = pick_grant;
          wd_d   = '0;
          err_d  = 1'b0;
          if (pick_grant == GRANT_D) begin
            addr_d  = dAddr;
            wdata_d = dWData;
            rd_d    = ~dWrite;
            wr_d    = dWrite;
            state_d = SERVE_D;
          end else begin
            addr_d  = iAddr;
            wdata_d = '0;
            rd_d    = 1'b1;
            wr_d    = 1'b0;
            state_d = SERVE_I;
          end
        end
      end

      SERVE_I, SERVE_D: begin
        if (MsReady) begin
          // Completion beats the watchdog when both happen in the same cycle.
          if (MsRead) begin
            if (state_q == SERVE_I) irdata_d = MsRData;
            else                    drdata_d = MsRData;
          end
          err_d   = 1'b0;
          rd_d    = 1'b0;
          wr_d    = 1'b0;
          iack_d  = (state_q == SERVE_I);
          dack_d  = (state_q == SERVE_D);
          state_d = DONE;
        end else if (wd_q == WD_LAST) begin
          // Give up; read data registers keep their previous contents.
          err_d   = 1'b1;
          rd_d    = 1'b0;
          wr_d    = 1'b0;
          iack_d  = (state_q == SERVE_I);
          dack_d  = (state_q == SERVE_D);
          state_d = DONE;
        end else begin
          wd_d = wd_q + 1'b1;
        end
      end

      DONE: begin
        // Ack/err were raised on entry; this bubble lets the requester drop req.
        err_d   = 1'b0;
        state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      last_q  <= GRANT_I;
      wd_q    <= '0;
      MsAddr  <= '0;
      MsWData <= '0;
      MsRead  <= 1'b0;
      MsWrite <= 1'b0;
      iAck    <= 1'b0;
      dAck    <= 1'b0;
      err     <= 1'b0;
      iRData  <= '0;
      dRData  <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      wd_q    <= wd_d;
      MsAddr  <= addr_d;
      MsWData <= wdata_d;
      MsRead  <= rd_d;
      MsWrite <= wr_d;
      iAck    <= iack_d;
      dAck    <= dack_d;
      err     <= err_d;
      iRData  <= irdata_d;
      dRData  <= drdata_d;
    end
  end

endmodule
